// File: rtl/axi4_lite_register_file.sv
// AXI4-Lite slave register file: W registers of N bytes, each RW, RO or W1C.
// Independent write (AW/W/B) and read (AR/R) channels, byte strobes,
// OKAY/SLVERR responses and per-register write/read side-effect strobes.
module axi4_lite_register_file #(
    parameter int unsigned      N         = 4,
    parameter int unsigned      A         = 32,
    parameter int unsigned      CLOG2_W   = 3,
    parameter int unsigned      W         = 1 << CLOG2_W,
    parameter logic [W-1:0]     RO_MASK   = '0,
    parameter logic [W-1:0]     W1C_MASK  = '0,
    parameter logic [N*8-1:0]   RESET_VAL = '0
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic [A-1:0]            awaddr,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [N*8-1:0]          wdata,
    input  logic [N-1:0]            wstrb,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [A-1:0]            araddr,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [N*8-1:0]          rdata,
    output logic [1:0]              rresp,
    output logic                    rvalid,
    input  logic                    rready,
    input  logic [W-1:0][N*8-1:0]   register_in,
    output logic [W-1:0][N*8-1:0]   register_out,
    output logic [W-1:0]            wr_en,
    output logic [W-1:0]            rd_en
);

    localparam int unsigned  DW          = N * 8;
    localparam int unsigned  OFF         = $clog2(N);
    localparam int unsigned  TOP         = CLOG2_W + OFF;
    localparam logic [1:0]   RESP_OKAY   = 2'b00;
    localparam logic [1:0]   RESP_SLVERR = 2'b10;
    localparam logic [W-1:0] ONE_HOT0    = W'(1);

    if (N != 4 && N != 8) begin : g_bad_bus_width
        $error("axi4_lite_register_file: N must be 4 or 8");
    end

    typedef enum logic {W_IDLE, W_RESP} w_state_e;
    typedef enum logic {R_IDLE, R_RESP} r_state_e;

    w_state_e w_state_q, w_state_d;
    r_state_e r_state_q, r_state_d;

    logic                  aw_held_q, aw_held_d;
    logic [A-1:0]          awaddr_q,  awaddr_d;
    logic                  w_held_q,  w_held_d;
    logic [DW-1:0]         wdata_q,   wdata_d;
    logic [N-1:0]          wstrb_q,   wstrb_d;
    logic [1:0]            bresp_q,   bresp_d;
    logic [W-1:0]          wr_en_q,   wr_en_d;
    logic [DW-1:0]         rdata_q,   rdata_d;
    logic [1:0]            rresp_q,   rresp_d;
    logic [W-1:0][DW-1:0]  regs_q,    regs_d;

    logic                  do_write;
    logic [CLOG2_W-1:0]    w_idx;
    logic                  w_oor;
    logic                  w_err;
    logic [W-1:0]          w_hit;
    logic [DW-1:0]         byte_mask;
    logic                  ar_hs;
    logic [CLOG2_W-1:0]    r_idx;
    logic                  r_oor;

    // Byte-lane offset bits do not take part in register selection.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{awaddr_q[OFF-1:0], araddr[OFF-1:0]};

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------

    // Write FSM state register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) w_state_q <= W_IDLE;
        else          w_state_q <= w_state_d;
    end

    // Write FSM next state: commit once AW and W are both held, then wait for bready
    always_comb begin
        w_state_d = w_state_q;
        case (w_state_q)
            W_IDLE:  if (do_write) w_state_d = W_RESP;
            W_RESP:  if (bready)   w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    // Write FSM outputs: each ready drops once its beat is held, both stay low in W_RESP
    always_comb begin
        awready  = (w_state_q == W_IDLE) && !aw_held_q;
        wready   = (w_state_q == W_IDLE) && !w_held_q;
        bvalid   = (w_state_q == W_RESP);
        do_write = (w_state_q == W_IDLE) && aw_held_q && w_held_q;
    end

    // Write address decode and target register one-hot
    always_comb begin
        w_idx = awaddr_q[TOP-1:OFF];
        w_oor = (awaddr_q >> TOP) != '0;
        w_err = w_oor || RO_MASK[w_idx];
        w_hit = (do_write && !w_err) ? (ONE_HOT0 << w_idx) : '0;
    end

    // Expand byte strobes into a bit mask
    always_comb begin
        byte_mask = '0;
        for (int unsigned b = 0; b < N; b++) begin
            byte_mask[b*8 +: 8] = {8{wstrb_q[b]}};
        end
    end

    // AW/W capture, response code and write strobe generation
    always_comb begin
        aw_held_d = aw_held_q;
        awaddr_d  = awaddr_q;
        w_held_d  = w_held_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bresp_d   = bresp_q;
        wr_en_d   = w_hit;
        if (awvalid && awready) begin
            aw_held_d = 1'b1;
            awaddr_d  = awaddr;
        end
        if (wvalid && wready) begin
            w_held_d = 1'b1;
            wdata_d  = wdata;
            wstrb_d  = wstrb;
        end
        if (do_write) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bresp_d   = w_err ? RESP_SLVERR : RESP_OKAY;
        end
    end

    // Write channel holding registers
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            aw_held_q <= 1'b0;
            awaddr_q  <= '0;
            w_held_q  <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bresp_q   <= RESP_OKAY;
            wr_en_q   <= '0;
        end else begin
            aw_held_q <= aw_held_d;
            awaddr_q  <= awaddr_d;
            w_held_q  <= w_held_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bresp_q   <= bresp_d;
            wr_en_q   <= wr_en_d;
        end
    end

    // ------------------------------------------------------------------
    // Register array
    // ------------------------------------------------------------------

    // Register next value: RW byte merge, W1C clear with hardware set taking priority
    always_comb begin
        regs_d = regs_q;
        for (int unsigned i = 0; i < W; i++) begin
            if (RO_MASK[i]) begin
                regs_d[i] = '0;
            end else if (W1C_MASK[i]) begin
                if (w_hit[i]) begin
                    regs_d[i] = regs_q[i] & ~(wdata_q & byte_mask);
                end
                regs_d[i] = regs_d[i] | register_in[i];
            end else if (w_hit[i]) begin
                regs_d[i] = (regs_q[i] & ~byte_mask) | (wdata_q & byte_mask);
            end
        end
    end

    // Register storage; RO slots hold zero
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int unsigned i = 0; i < W; i++) begin
                regs_q[i] <= RO_MASK[i] ? '0 : RESET_VAL;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------

    // Read FSM state register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_state_q <= R_IDLE;
        else          r_state_q <= r_state_d;
    end

    // Read FSM next state: one outstanding read, released by rready
    always_comb begin
        r_state_d = r_state_q;
        case (r_state_q)
            R_IDLE:  if (arvalid) r_state_d = R_RESP;
            R_RESP:  if (rready)  r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    // Read FSM outputs, address decode and read strobe on the AR handshake
    always_comb begin
        arready = (r_state_q == R_IDLE);
        rvalid  = (r_state_q == R_RESP);
        ar_hs   = arvalid && arready;
        r_idx   = araddr[TOP-1:OFF];
        r_oor   = (araddr >> TOP) != '0;
        rd_en   = (ar_hs && !r_oor) ? (ONE_HOT0 << r_idx) : '0;
    end

    // Read data select; captured only on the handshake so it holds while rvalid waits
    always_comb begin
        rdata_d = rdata_q;
        rresp_d = rresp_q;
        if (ar_hs) begin
            if (r_oor) begin
                rdata_d = '0;
                rresp_d = RESP_SLVERR;
            end else begin
                rdata_d = RO_MASK[r_idx] ? register_in[r_idx] : regs_q[r_idx];
                rresp_d = RESP_OKAY;
            end
        end
    end

    // Read response registers
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rdata_q <= '0;
            rresp_q <= RESP_OKAY;
        end else begin
            rdata_q <= rdata_d;
            rresp_q <= rresp_d;
        end
    end

    assign bresp        = bresp_q;
    assign wr_en        = wr_en_q;
    assign rdata        = rdata_q;
    assign rresp        = rresp_q;
    assign register_out = regs_q;

endmodule

// File: tb/tb_axi4_lite_register_file.sv
// Directed self-checking bench for axi4_lite_register_file.
// Register 2 is W1C, register 3 is RO, all others RW.
module tb_axi4_lite_register_file;

    logic             aclk = 1'b0;
    logic             aresetn;
    logic [31:0]      awaddr;
    logic             awvalid;
    logic             awready;
    logic [31:0]      wdata;
    logic [3:0]       wstrb;
    logic             wvalid;
    logic             wready;
    logic [1:0]       bresp;
    logic             bvalid;
    logic             bready;
    logic [31:0]      araddr;
    logic             arvalid;
    logic             arready;
    logic [31:0]      rdata;
    logic [1:0]       rresp;
    logic             rvalid;
    logic             rready;
    logic [7:0][31:0] register_in;
    logic [7:0][31:0] register_out;
    logic [7:0]       wr_en;
    logic [7:0]       rd_en;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [1:0]  resp;
    logic [31:0] data;
    int          pulses;

    axi4_lite_register_file #(
        .N         (4),
        .A         (32),
        .CLOG2_W   (3),
        .RO_MASK   (8'h08),
        .W1C_MASK  (8'h04),
        .RESET_VAL (32'h0000_0000)
    ) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .awaddr       (awaddr),
        .awvalid      (awvalid),
        .awready      (awready),
        .wdata        (wdata),
        .wstrb        (wstrb),
        .wvalid       (wvalid),
        .wready       (wready),
        .bresp        (bresp),
        .bvalid       (bvalid),
        .bready       (bready),
        .araddr       (araddr),
        .arvalid      (arvalid),
        .arready      (arready),
        .rdata        (rdata),
        .rresp        (rresp),
        .rvalid       (rvalid),
        .rready       (rready),
        .register_in  (register_in),
        .register_out (register_out),
        .wr_en        (wr_en),
        .rd_en        (rd_en)
    );

    always #5 aclk = ~aclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full write transaction; AW and W presented together, response taken immediately.
    task automatic wr(input logic [31:0] addr, input logic [31:0] d, input logic [3:0] s,
                      output logic [1:0] r);
        int  cnt;
        logic aw_go, w_go;
        @(negedge aclk);
        awaddr = addr; awvalid = 1'b1;
        wdata  = d;    wstrb   = s; wvalid = 1'b1;
        cnt = 0;
        while ((awvalid || wvalid) && cnt < 20) begin
            aw_go = awready;
            w_go  = wready;
            @(negedge aclk);
            if (aw_go) awvalid = 1'b0;
            if (w_go)  wvalid  = 1'b0;
            cnt++;
        end
        chk("wr_accept", {62'd0, awvalid, wvalid}, 64'd0);
        awvalid = 1'b0; wvalid = 1'b0;
        cnt = 0;
        while (!bvalid && cnt < 20) begin
            @(negedge aclk);
            cnt++;
        end
        chk("wr_bvalid", bvalid, 1);
        r = bresp;
        bready = 1'b1;
        @(negedge aclk);
        bready = 1'b0;
    endtask

    // Full read transaction.
    task automatic rd(input logic [31:0] addr, output logic [31:0] d, output logic [1:0] r);
        int   cnt;
        logic go;
        @(negedge aclk);
        araddr = addr; arvalid = 1'b1;
        cnt = 0;
        while (arvalid && cnt < 20) begin
            go = arready;
            @(negedge aclk);
            if (go) arvalid = 1'b0;
            cnt++;
        end
        arvalid = 1'b0;
        cnt = 0;
        while (!rvalid && cnt < 20) begin
            @(negedge aclk);
            cnt++;
        end
        chk("rd_rvalid", rvalid, 1);
        d = rdata;
        r = rresp;
        rready = 1'b1;
        @(negedge aclk);
        rready = 1'b0;
    endtask

    initial begin
        aresetn = 1'b0;
        awaddr = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wvalid = 1'b0;
        bready = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;
        register_in = '0;
        register_in[3] = 32'hCAFE_F00D;

        // Reset state
        repeat (2) @(negedge aclk);
        chk("rst_awready", awready, 1);
        chk("rst_wready", wready, 1);
        chk("rst_arready", arready, 1);
        chk("rst_bvalid", bvalid, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_bresp", bresp, 0);
        chk("rst_rresp", rresp, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_regout0", register_out[0], 0);
        chk("rst_regout2", register_out[2], 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_rd_en", rd_en, 0);
        aresetn = 1'b1;

        // 1: AW+W in the same cycle, bvalid two clocks after presentation
        @(negedge aclk);
        awaddr = 32'h4; awvalid = 1'b1;
        wdata = 32'hA5A5_A5A5; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge aclk);
        awvalid = 1'b0; wvalid = 1'b0;
        chk("t1_bvalid_early", bvalid, 0);
        chk("t1_awready_low", awready, 0);
        chk("t1_wready_low", wready, 0);
        @(negedge aclk);
        chk("t1_bvalid", bvalid, 1);
        chk("t1_bresp", bresp, 2'b00);
        chk("t1_regout1", register_out[1], 32'hA5A5_A5A5);
        chk("t1_wr_en", wr_en, 8'h02);
        bready = 1'b1;
        @(negedge aclk);
        bready = 1'b0;
        chk("t1_bvalid_done", bvalid, 0);
        chk("t1_awready_back", awready, 1);
        chk("t1_wr_en_done", wr_en, 0);
        araddr = 32'h4; arvalid = 1'b1;
        #1;
        chk("t1_rd_en", rd_en, 8'h02);
        @(negedge aclk);
        arvalid = 1'b0;
        chk("t1_rvalid", rvalid, 1);
        chk("t1_rdata", rdata, 32'hA5A5_A5A5);
        chk("t1_rresp", rresp, 2'b00);
        chk("t1_arready_low", arready, 0);
        chk("t1_rd_en_done", rd_en, 0);
        rready = 1'b1;
        @(negedge aclk);
        rready = 1'b0;
        chk("t1_rvalid_done", rvalid, 0);
        chk("t1_arready_back", arready, 1);

        // 2: W three clocks ahead of AW, single wr_en pulse
        wdata = 32'h1122_3344; wstrb = 4'hF; wvalid = 1'b1;
        pulses = 0;
        @(negedge aclk);
        wvalid = 1'b0;
        pulses += int'(wr_en[1]);
        chk("t2_wready_low", wready, 0);
        repeat (2) begin
            @(negedge aclk);
            pulses += int'(wr_en[1]);
        end
        chk("t2_no_bvalid", bvalid, 0);
        awaddr = 32'h4; awvalid = 1'b1;
        @(negedge aclk);
        awvalid = 1'b0;
        pulses += int'(wr_en[1]);
        repeat (4) begin
            @(negedge aclk);
            pulses += int'(wr_en[1]);
        end
        chk("t2_wr_en_pulses", pulses, 1);
        chk("t2_bvalid", bvalid, 1);
        chk("t2_bresp", bresp, 2'b00);
        chk("t2_regout1", register_out[1], 32'h1122_3344);
        bready = 1'b1;
        @(negedge aclk);
        bready = 1'b0;

        // 3: partial byte strobe
        wr(32'h0, 32'h1234_5678, 4'hF, resp);
        chk("t3_resp_full", resp, 2'b00);
        wr(32'h0, 32'h0000_FF00, 4'b0010, resp);
        chk("t3_resp_strb", resp, 2'b00);
        rd(32'h0, data, resp);
        chk("t3_rdata", data, 32'h1234_FF78);

        // 4: W1C register (index 2)
        @(negedge aclk);
        register_in[2] = 32'h5;
        @(negedge aclk);
        register_in[2] = 32'h0;
        rd(32'h8, data, resp);
        chk("t4_set", data, 32'h5);
        wr(32'h8, 32'h1, 4'hF, resp);
        chk("t4_clr_resp", resp, 2'b00);
        rd(32'h8, data, resp);
        chk("t4_clr", data, 32'h4);
        register_in[2] = 32'h4;
        wr(32'h8, 32'h4, 4'h1, resp);
        rd(32'h8, data, resp);
        chk("t4_set_wins", data, 32'h4);
        chk("t4_set_wins_out", register_out[2], 32'h4);
        register_in[2] = 32'h0;
        wr(32'h8, 32'h4, 4'hF, resp);
        rd(32'h8, data, resp);
        chk("t4_clr_last", data, 32'h0);

        // 5: RO and out-of-range accesses
        rd(32'hC, data, resp);
        chk("t5_ro_rdata", data, 32'hCAFE_F00D);
        chk("t5_ro_rresp", resp, 2'b00);
        wr(32'hC, 32'hFFFF_FFFF, 4'hF, resp);
        chk("t5_ro_bresp", resp, 2'b10);
        chk("t5_ro_regout", register_out[3], 32'h0);
        wr(32'd32, 32'hFFFF_FFFF, 4'hF, resp);
        chk("t5_oor_bresp", resp, 2'b10);
        chk("t5_oor_alias", register_out[0], 32'h1234_FF78);
        rd(32'd32, data, resp);
        chk("t5_oor_rdata", data, 32'h0);
        chk("t5_oor_rresp", resp, 2'b10);
        rd(32'h8000_0004, data, resp);
        chk("t5_hi_rresp", resp, 2'b10);

        // 6: stalled responses, concurrent read of a register written that cycle, async reset
        @(negedge aclk);
        awaddr = 32'h4; awvalid = 1'b1;
        wdata = 32'h9988_7766; wstrb = 4'hF; wvalid = 1'b1;
        @(negedge aclk);
        awvalid = 1'b0; wvalid = 1'b0;
        araddr = 32'h4; arvalid = 1'b1;
        @(negedge aclk);
        arvalid = 1'b0;
        repeat (5) begin
            chk("t6_bvalid_hold", bvalid, 1);
            chk("t6_bresp_hold", bresp, 2'b00);
            chk("t6_rvalid_hold", rvalid, 1);
            chk("t6_rdata_hold", rdata, 32'h1122_3344);
            @(negedge aclk);
        end
        chk("t6_regout1", register_out[1], 32'h9988_7766);
        #2;
        aresetn = 1'b0;
        #1;
        chk("t6_rst_bvalid", bvalid, 0);
        chk("t6_rst_rvalid", rvalid, 0);
        chk("t6_rst_rdata", rdata, 0);
        chk("t6_rst_regout1", register_out[1], 0);
        chk("t6_rst_awready", awready, 1);
        @(negedge aclk);
        aresetn = 1'b1;
        rd(32'h4, data, resp);
        chk("t6_post_rdata", data, 32'h0);
        chk("t6_post_rresp", resp, 2'b00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
